// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    TRAP = 3'd1,
    JMPR = 3'd2,
    JMP  = 3'd3,
    JMPB = 3'd4
  } redir_e;

  // Mask of the PC low bits that must be zero for a legal fetch target.
  function automatic logic [63:0] align_mask(input int unsigned align);
    return (64'd1 << align) - 64'd1;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side handshake between the PC generator and instruction fetch.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;

  modport master (output pc, output pc_valid, output flush, input pc_ready);
  modport slave  (input pc, input pc_valid, input flush, output pc_ready);
endinterface

// File: rtl/pc_target.sv
// Redirect priority encoder, target arithmetic and alignment check.
module pc_target
  import pc_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BR_SHIFT = 1,
  parameter int ALIGN    = 2
) (
  input  logic            trap_en_i,
  input  logic            jmpr_en_i,
  input  logic            jmp_en_i,
  input  logic            jmpb_en_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] target_o,
  output redir_e          redir_o,
  output logic            misalign_next_o
);

  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] rel_tgt;
  logic [XLEN-1:0] reg_tgt;
  logic [XLEN-1:0] raw_tgt;

  assign mask    = XLEN'(align_mask(ALIGN));
  assign rel_tgt = br_pc_i + (offset_i << BR_SHIFT);
  assign reg_tgt = {offset_i[XLEN-1:1], 1'b0};

  always_comb begin
    redir_o = NONE;
    raw_tgt = trap_vec_i;
    if (trap_en_i) begin
      redir_o = TRAP;
      raw_tgt = trap_vec_i;
    end else if (jmpr_en_i) begin
      redir_o = JMPR;
      raw_tgt = reg_tgt;
    end else if (jmp_en_i) begin
      redir_o = JMP;
      raw_tgt = rel_tgt;
    end else if (jmpb_en_i) begin
      redir_o = JMPB;
      raw_tgt = rel_tgt;
    end
  end

  // The trap vector is trusted; only computed targets can fault.
  assign misalign_next_o = (redir_o != NONE) && (redir_o != TRAP) && (|(raw_tgt & mask));
  assign target_o        = misalign_next_o ? trap_vec_i : raw_tgt;

endmodule

// File: rtl/pc_gen.sv
// Next-PC unit: boot/run/halt FSM, PC register, redirect pulses and fetch counter.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int              BR_SHIFT  = 1,
  parameter int              ALIGN     = 2,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  pc_gen_if.master         fetch_if,
  input  logic             jmp_en,
  input  logic             jmpb_en,
  input  logic             jmpr_en,
  input  logic [XLEN-1:0]  offset,
  input  logic [XLEN-1:0]  br_pc,
  input  logic             trap_en,
  input  logic [XLEN-1:0]  trap_vec,
  input  logic             halt_en,
  output logic             misalign,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic            pc_valid_q;
  logic            flush_q;
  logic            misalign_q;
  logic            halted_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN-1:0]  pc_seq_d;
  logic [CNT_W-1:0] cnt_d;
  logic [XLEN-1:0]  target;
  redir_e           redir;
  logic             misalign_next;
  logic             fire;

  pc_target #(
    .XLEN     (XLEN),
    .BR_SHIFT (BR_SHIFT),
    .ALIGN    (ALIGN)
  ) u_target (
    .trap_en_i       (trap_en),
    .jmpr_en_i       (jmpr_en),
    .jmp_en_i        (jmp_en),
    .jmpb_en_i       (jmpb_en),
    .offset_i        (offset),
    .br_pc_i         (br_pc),
    .trap_vec_i      (trap_vec),
    .target_o        (target),
    .redir_o         (redir),
    .misalign_next_o (misalign_next)
  );

  assign fire     = pc_valid_q && fetch_if.pc_ready;
  assign pc_seq_d = pc_q + XLEN'(64'd1 << ALIGN);
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_valid_q <= 1'b1;
        end
        RUN: begin
          // A handshake completes even when the same cycle redirects or halts.
          if (fire) cnt_q <= cnt_d;
          if (halt_en) begin
            state_q    <= HALT;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end else if (redir != NONE) begin
            pc_q       <= target;
            flush_q    <= 1'b1;
            misalign_q <= misalign_next;
          end else if (fire) begin
            pc_q <= pc_seq_d;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q    <= BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_if.pc       = pc_q;
  assign fetch_if.pc_valid = pc_valid_q;
  assign fetch_if.flush    = flush_q;
  assign misalign          = misalign_q;
  assign halted            = halted_q;
  assign fetch_cnt         = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then randomized redirects.
module tb_pc_gen;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        jmp_en, jmpb_en, jmpr_en, trap_en, halt_en;
  logic [31:0] offset, br_pc, trap_vec;
  logic        misalign, halted;
  logic [31:0] fetch_cnt;

  pc_gen_if #(.XLEN(32)) fetch_if ();

  pc_gen #(
    .XLEN      (32),
    .RESET_VEC (RESET_VEC),
    .BR_SHIFT  (1),
    .ALIGN     (2),
    .CNT_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch_if  (fetch_if.master),
    .jmp_en    (jmp_en),
    .jmpb_en   (jmpb_en),
    .jmpr_en   (jmpr_en),
    .offset    (offset),
    .br_pc     (br_pc),
    .trap_en   (trap_en),
    .trap_vec  (trap_vec),
    .halt_en   (halt_en),
    .misalign  (misalign),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        flush;
    logic        mis;
    logic        halted;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a fetch address, a fetch count and two mode flags.
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  logic [31:0] m_pc   = RESET_VEC;
  logic [31:0] m_cnt  = 32'd0;
  bit          m_flush, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input bit r, input bit rdy, input bit j, input bit jb, input bit jr,
                      input bit t, input bit h, input logic [31:0] off,
                      input logic [31:0] bp, input logic [31:0] tv);
    logic [31:0] tgt;
    exp_t e;
    @(negedge clk);
    rst = r; fetch_if.pc_ready = rdy;
    jmp_en = j; jmpb_en = jb; jmpr_en = jr; trap_en = t; halt_en = h;
    offset = off; br_pc = bp; trap_vec = tv;
    m_flush = 1'b0;
    m_mis   = 1'b0;
    if (!r) begin
      m_boot = 1'b1; m_halt = 1'b0; m_pc = RESET_VEC; m_cnt = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      if (rdy) m_cnt = m_cnt + 32'd1;
      if (h) begin
        m_halt = 1'b1;
      end else if (t || jr || j || jb) begin
        if (t)       tgt = tv;
        else if (jr) tgt = off - (off % 2);
        else         tgt = bp + off * 2;
        if (!t && (tgt % 4) != 0) begin
          tgt   = tv;
          m_mis = 1'b1;
        end
        m_flush = 1'b1;
        m_pc    = tgt;
      end else if (rdy) begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.valid = !m_boot && !m_halt; e.flush = m_flush;
    e.mis = m_mis; e.halted = m_halt; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected record per clock edge issued by the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pc",        fetch_if.pc,              e.pc);
        chk("pc_valid",  32'(fetch_if.pc_valid),   32'(e.valid));
        chk("flush",     32'(fetch_if.flush),      32'(e.flush));
        chk("misalign",  32'(misalign),            32'(e.mis));
        chk("halted",    32'(halted),              32'(e.halted));
        chk("fetch_cnt", fetch_cnt,                e.cnt);
        $display("cycle t=%0t pc=%h valid=%0b flush=%0b misalign=%0b halted=%0b cnt=%0d",
                 $time, fetch_if.pc, fetch_if.pc_valid, fetch_if.flush, misalign, halted, fetch_cnt);
      end
    end
  end

  initial begin
    logic [31:0] tv, off, bp;
    rst = 1'b0; fetch_if.pc_ready = 1'b0;
    jmp_en = 0; jmpb_en = 0; jmpr_en = 0; trap_en = 0; halt_en = 0;
    offset = '0; br_pc = '0; trap_vec = '0;
    tv = 32'h8000_0100;

    // Reset, boot, free-run, stall at 0x8000_0008, then a relative jump.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 0, 1, 0, 0, 0, 0, 32'h10, 32'h8000_0004, tv);
    step(1, 1, 0, 0, 1, 1, 0, 32'h8000_0201, 0, tv);
    step(1, 1, 0, 0, 1, 0, 0, 32'h8000_0201, 0, tv);
    step(1, 1, 0, 1, 0, 0, 0, 32'h1, 32'h8000_0000, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 1, 0, 0, 0, 1, 32'h40, 32'h8000_0000, tv);
    step(1, 1, 1, 0, 1, 1, 0, 32'h40, 32'h8000_0000, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);
    step(1, 1, 1, 0, 0, 0, 0, 32'h10, 32'hFFFF_FFF0, tv);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, tv);

    // Randomized traffic with occasional halts and resets.
    for (int i = 0; i < 500; i++) begin
      off = $urandom();
      if ($urandom_range(1, 0) == 1) off = off & ~32'd1;
      bp = $urandom() & ~32'd3;
      tv = $urandom() & ~32'd3;
      step(($urandom_range(49, 0) != 0), ($urandom_range(3, 0) != 0),
           ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0),
           ($urandom_range(7, 0) == 0), ($urandom_range(11, 0) == 0),
           ($urandom_range(99, 0) == 0), off, bp, tv);
    end

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, tv);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator feeding instruction fetch. It replaces the fixed 32-bit PC with a next-PC unit that is generic in address width and reset vector. It adds a valid/ready handshake toward fetch, prioritised redirects (trap, register jump, relative jump/branch), misalignment trapping, a halt state, a one-cycle flush pulse, and a fetch counter. It sits between the decode/execute redirect logic and the instruction-memory port.

## Interface
- XLEN, 32: address/PC width.
- RESET_VEC, 32'h8000_0000: PC value after reset (XLEN bits).
- BR_SHIFT, 1: left shift applied to relative offsets (jmp/jmpb).
- ALIGN, 2: number of PC LSBs that must be zero for a legal target (1..3).
- CNT_W, 32: width of fetch counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on posedge clk).
- pc  out  XLEN  current fetch address.
- pc_valid  out  1  pc is a request for fetch.
- pc_ready  in  1  fetch accepts pc this cycle.
- jmp_en  in  1  relative jump request.
- jmpb_en  in  1  taken-branch request.
- jmpr_en  in  1  register jump request; target is offset with bit0 cleared.
- offset  in  XLEN  jump offset (jmp/jmpb) or absolute target (jmpr).
- br_pc  in  XLEN  PC of the redirecting instruction (base for jmp/jmpb).
- trap_en  in  1  trap request.
- trap_vec  in  XLEN  trap handler address.
- halt_en  in  1  stop fetching (ebreak).
- flush  out  1  one-cycle pulse: in-flight fetch must be discarded.
- misalign  out  1  one-cycle pulse: redirect target was misaligned, trap taken.
- halted  out  1  block is in HALT.
- fetch_cnt  out  CNT_W  number of completed pc handshakes.

## Operation
- States: BOOT, RUN, HALT.
- BOOT: entered on reset and lasts one cycle; pc_valid=0, then goes to RUN.
- RUN: pc_valid=1.
  - Handshake (pc_valid && pc_ready) with no redirect: pc <= pc + (1<<ALIGN), fetch_cnt++.
  - pc_ready=0 with no redirect: pc holds (stall).
- Redirect priority, evaluated only in RUN: trap_en > jmpr_en > jmp_en > jmpb_en. Lower-priority requests in the same cycle are dropped.
- Targets, all arithmetic modulo 2^XLEN:
  - trap: trap_vec.
  - jmpr: offset & ~1.
  - jmp/jmpb: br_pc + (offset << BR_SHIFT).
- Misaligned target (target[ALIGN-1:0] != 0, trap excluded): pc <= trap_vec, misalign pulses.
- Any redirect: pc <= target next cycle, flush pulses in that cycle. A redirect overrides a pending (unaccepted) pc. If the redirect cycle also had a handshake, fetch_cnt still increments.
- halt_en in RUN goes to HALT and has priority over redirects in the same cycle. In HALT, pc holds, pc_valid=0, halted=1, and all inputs are ignored. Only reset leaves HALT.
- fetch_cnt wraps at 2^CNT_W.
- Reset values: pc=RESET_VEC, pc_valid=0, flush=0, misalign=0, halted=0, fetch_cnt=0, state=BOOT. Reset mid-operation aborts everything, including pending redirects.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Redirect presented in cycle N → pc=target and flush=1 in cycle N+1, with pc_valid=1 in N+1.
- Handshake in cycle N → pc advances in N+1.
- First valid request arrives 2 cycles after rst deasserts: the BOOT cycle, then RUN.
- flush and misalign are high exactly one cycle per event. Back-to-back redirects produce back-to-back pulses.

## Structure
- Package pc_pkg holds:
  - pc_state_e {BOOT, RUN, HALT}.
  - redir_e {NONE, TRAP, JMPR, JMP, JMPB}.
  - Function for the alignment mask.
- Sub-module pc_target: combinational priority encode, target computation and misalign check. It produces target, redir_e and misalign_next.
- pc_gen holds the FSM, PC register, pulse registers and counter.

## Test plan
- Reset then free-run with pc_ready=1: pc_valid=0 for one cycle, then pc = 0x8000_0000, 0x8000_0004, 0x8000_0008; fetch_cnt=3 after three handshakes.
- pc_ready=0 for 3 cycles at pc=0x8000_0008: pc holds and fetch_cnt is unchanged. Then jmp_en with br_pc=0x8000_0004, offset=0x10 → next cycle pc=0x8000_0024, flush=1.
- Same cycle trap_en (trap_vec=0x8000_0100) + jmpr_en (offset=0x8000_0201) → pc=0x8000_0100 and misalign=0. Then jmpr_en alone with offset=0x8000_0201 → pc=0x8000_0200.
- jmpb_en with br_pc=0x8000_0000, offset=0x1 → target 0x8000_0002 is misaligned → pc=trap_vec, misalign=1 and flush=1 for one cycle.
- halt_en together with jmp_en → halted=1, pc_valid=0, pc unchanged. Further redirects are ignored. Then rst=0 for one cycle → pc=RESET_VEC, halted=0, fetch_cnt=0.
- Offset wrap: br_pc=0xFFFF_FFF0, offset=0x10, BR_SHIFT=1 → pc=0x0000_0010.
